// File: rtl/maxnet_pkg.sv
// Shared types and constants for the four-input MaxNet winner-take-all engine.
package maxnet_pkg;

    localparam int IN_W      = 5;
    localparam int FRAC_W    = 8;
    localparam int EPS_SHIFT = 3;
    localparam int ACT_W     = IN_W + FRAC_W;
    localparam int SUM_W     = ACT_W + 2;
    localparam int MAX_ITER  = 63;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;

    typedef logic [ACT_W-1:0] act_t;

endpackage

// File: rtl/maxnet_if.sv
// Start/done handshake bundle carrying the four scores and the winning score.
interface maxnet_if;
    import maxnet_pkg::*;

    logic            start;
    logic [IN_W-1:0] X1;
    logic [IN_W-1:0] X2;
    logic [IN_W-1:0] X3;
    logic [IN_W-1:0] X4;
    logic            done;
    logic [IN_W-1:0] result;

    modport master (
        output start, X1, X2, X3, X4,
        input  done, result
    );

    modport slave (
        input  start, X1, X2, X3, X4,
        output done, result
    );

endinterface

// File: rtl/maxnet_neuron.sv
// One lateral-inhibition step: ReLU(a - ((S - a) >> EPS_SHIFT)).
module maxnet_neuron
    import maxnet_pkg::*;
(
    input  act_t             a,
    input  logic [SUM_W-1:0] s,
    output act_t             q
);

    logic [SUM_W-1:0] ax;
    logic [SUM_W-1:0] inh;

    assign ax  = SUM_W'(a);
    assign inh = (s - ax) >> EPS_SHIFT;
    assign q   = (ax > inh) ? ACT_W'(ax - inh) : '0;

endmodule

// File: rtl/maxnet.sv
// Four-input MaxNet: loads scores, iterates inhibition until one survives,
// then reports the winner's original score.
module maxnet
    import maxnet_pkg::*;
(
    input logic     clk,
    input logic     rst,
    maxnet_if.slave bus
);

    state_t           state;
    state_t           state_nx;
    logic [IN_W-1:0]  xin  [4];
    logic [IN_W-1:0]  orig [4];
    act_t             a    [4];
    act_t             a_nx [4];
    logic [CNT_W-1:0] cnt;
    logic [3:0]       nzm;
    logic [3:0]       prev;
    logic [2:0]       nz;
    logic [SUM_W-1:0] sum;
    logic             finish;
    logic [1:0]       win_one;
    logic [1:0]       win_prev;
    logic [1:0]       win_max;
    logic [1:0]       win;
    act_t             best;
    logic [IN_W-1:0]  res_nx;
    logic [IN_W-1:0]  result;

    assign xin[0] = bus.X1;
    assign xin[1] = bus.X2;
    assign xin[2] = bus.X3;
    assign xin[3] = bus.X4;

    for (genvar g = 0; g < 4; g++) begin : g_n
        assign nzm[g] = (a[g] != '0);
        maxnet_neuron u_neuron (
            .a (a[g]),
            .s (sum),
            .q (a_nx[g])
        );
    end

    assign sum = SUM_W'(a[0]) + SUM_W'(a[1])
               + SUM_W'(a[2]) + SUM_W'(a[3]);
    assign nz  = 3'(nzm[0]) + 3'(nzm[1])
               + 3'(nzm[2]) + 3'(nzm[3]);
    assign finish = (nz <= 3'd1)
                 || (cnt == CNT_W'(MAX_ITER));

    always_comb begin
        win_one  = '0;
        win_prev = '0;
        win_max  = '0;
        best     = a[0];
        for (int i = 3; i >= 0; i--) begin
            if (nzm[i])  win_one  = 2'(i);
            if (prev[i]) win_prev = 2'(i);
        end
        for (int i = 1; i < 4; i++) begin
            if (a[i] > best) begin
                best    = a[i];
                win_max = 2'(i);
            end
        end
        if (nz == 3'd1)      win = win_one;
        else if (nz == 3'd0) win = win_prev;
        else                 win = win_max;
        // Empty prev mask with no survivors means every input was zero.
        if (nz == 3'd0 && prev == 4'd0) res_nx = '0;
        else                            res_nx = orig[win];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = LOAD;
            LOAD:    state_nx = ITER;
            ITER:    if (finish) state_nx = DONE;
            DONE:    if (bus.start) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            orig   <= '{default: '0};
            a      <= '{default: '0};
            cnt    <= '0;
            prev   <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) orig <= xin;
                end
                LOAD: begin
                    for (int i = 0; i < 4; i++)
                        a[i] <= {orig[i], {FRAC_W{1'b0}}};
                    cnt  <= '0;
                    prev <= '0;
                end
                ITER: begin
                    if (finish) begin
                        result <= res_nx;
                    end else begin
                        a    <= a_nx;
                        prev <= nzm;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done   = (state == DONE);
    assign bus.result = result;

endmodule

// File: tb/tb_maxnet.sv
// Scoreboard bench for maxnet: runs push expected winners, a monitor pops on done.
module tb_maxnet;
    import maxnet_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    maxnet_if bus ();

    maxnet dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int              errors = 0;
    int              checks = 0;
    logic [IN_W-1:0] exp_q [$];
    logic            done_q = 1'b0;
    int              lat;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int max4(input int p, input int q,
                                input int r, input int s);
        int m;
        m = p;
        if (q > m) m = q;
        if (r > m) m = r;
        if (s > m) m = s;
        return m;
    endfunction

    // Monitor: compare on every rising edge of done.
    always @(negedge clk) begin
        if (rst) begin
            done_q = 1'b0;
        end else begin
            if (bus.done && !done_q) begin
                if (exp_q.size() == 0)
                    check("unexpected_done", 1, 0);
                else
                    check("result", int'(bus.result), int'(exp_q.pop_front()));
            end
            done_q = bus.done;
        end
    end

    // mode 0: plain, 1: start/X noise during ITER, 2: check done drops
    task automatic run(input int x1, input int x2, input int x3,
                       input int x4, input int mode, output int n);
        bus.X1    = 5'(x1);
        bus.X2    = 5'(x2);
        bus.X3    = 5'(x3);
        bus.X4    = 5'(x4);
        bus.start = 1'b1;
        exp_q.push_back(5'(max4(x1, x2, x3, x4)));
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        if (mode == 2) check("done_drop", int'(bus.done), 0);
        do begin
            if (mode == 1 && n >= 2 && n < 5) begin
                bus.start = 1'b1;
                bus.X1 = 5'd1;
                bus.X2 = 5'd1;
                bus.X3 = 5'd1;
                bus.X4 = 5'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end while (!bus.done && n < 90);
        bus.start = 1'b0;
        check("done_seen", int'(bus.done), 1);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.X1    = '0;
        bus.X2    = '0;
        bus.X3    = '0;
        bus.X4    = '0;
        repeat (2) @(negedge clk);
        check("rst_done", int'(bus.done), 0);
        check("rst_result", int'(bus.result), 0);
        rst = 1'b0;
        @(negedge clk);

        run(2, 7, 1, 6, 0, lat);
        check("lat_bound", int'(lat <= MAX_ITER + 3), 1);
        run(0, 0, 9, 0, 0, lat);
        check("lat_single", lat, 3);
        run(0, 0, 0, 0, 0, lat);
        check("lat_zero", lat, 3);
        run(5, 5, 1, 0, 0, lat);
        run(31, 3, 31, 2, 0, lat);
        run(30, 29, 28, 31, 1, lat);

        // Abort a run mid-ITER with reset.
        bus.X1    = 5'd2;
        bus.X2    = 5'd7;
        bus.X3    = 5'd1;
        bus.X4    = 5'd6;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_done", int'(bus.done), 0);
        check("abort_result", int'(bus.result), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_done", int'(bus.done), 0);

        run(1, 2, 3, 4, 0, lat);
        run(4, 12, 8, 3, 2, lat);
        run(17, 0, 0, 0, 2, lat);
        check("lat_b2b", lat, 3);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maxnet.md
Name: maxnet

Overview:
- Four-input winner-take-all (MaxNet) engine.
- On a start request it loads four unsigned 5-bit scores and runs the iterative lateral-inhibition recurrence until one activation is left.
- It then reports the winner's original score.
- It is a standalone compute block driven by a simple start/done handshake.

Parameters:
- IN_W, 5: width of X1..X4 and result.
- FRAC_W, 8: fractional bits of the internal activations. Activation width is IN_W+FRAC_W = 13, unsigned.
- EPS_SHIFT, 3: inhibition weight epsilon = 2^-EPS_SHIFT = 0.125. It must be below 1/4.
- MAX_ITER, 63: safety cap on update iterations.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request, sampled at a clock edge.
- X1  in  5  unsigned score 1.
- X2  in  5  unsigned score 2.
- X3  in  5  unsigned score 3.
- X4  in  5  unsigned score 4.
- done  out  1  run complete; level signal.
- result  out  5  original score of the winning input.

Behaviour:
- Interface rules:
  - One clock; reset is synchronous and active-high.
  - On rst: state=IDLE, done=0, result=0, activations=0, iteration counter=0.
  - rst asserted mid-run aborts the run the same edge.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE:
  - start=1 at an edge -> LOAD.
  - At that edge, capture X1..X4 into orig[i].
- LOAD (one cycle):
  - a[i] = orig[i] << FRAC_W.
  - Clear the counter.
  - -> ITER.
- ITER (one cycle per step):
  - nz = number of a[i] != 0, computed from the registered activations.
  - If nz <= 1, or counter == MAX_ITER -> DONE, selecting the winner as below.
  - Otherwise, update all four in parallel:
    - S = a1+a2+a3+a4, using 15-bit width so it cannot overflow.
    - inh_i = (S - a[i]) >> EPS_SHIFT, truncated.
    - a[i] <= (a[i] > inh_i) ? a[i]-inh_i : 0 (ReLU clamp).
    - counter++.
- Winner selection (registered into result at the edge entering DONE):
  - nz == 1: the unique nonzero index.
  - nz == 0 after at least one update (tied maxima died together): the lowest index that was nonzero before the final update. A prev-nonzero mask is kept for this.
  - nz == 0 at the first check (all inputs zero): result = 0.
  - Counter cap reached: the index with the largest a[i], lowest index on ties.
  - result = orig[winner].
- DONE:
  - done=1 and result hold stable.
  - start=1 -> LOAD with fresh capture; done drops at that edge.
- start is ignored in LOAD and ITER; X1..X4 are only sampled at the start edge.
- Latency: start sampled at edge k -> LOAD at k+1 -> done=1 after edge k+2+N, where N is the number of update iterations (N=0 if at most one input is nonzero).

Decomposition:
- Package maxnet_pkg holds:
  - the state enum;
  - constants IN_W, FRAC_W, EPS_SHIFT, ACT_W;
  - the activation typedef.
- One natural sub-module, maxnet_neuron: it computes one ReLU(a - (S - a)>>EPS_SHIFT) update and is instantiated 4 times.
- Winner select and the FSM stay in the top level.

Test Plan:
- rst pulse, then start with X=(2,7,1,6) -> done=1 within MAX_ITER+2 cycles, result=7.
- X=(0,0,9,0) -> no updates; done exactly 3 edges after start, result=9.
- X=(0,0,0,0) -> done after 3 edges, result=0.
- Ties:
  - X=(5,5,1,0) -> result=5.
  - X=(31,3,31,2) -> result=31, winner index 1.
- Max value at the last input: X=(30,29,28,31) -> result=31; start pulses during ITER have no effect.
- Reset and restart:
  - Assert rst during ITER -> next edge done=0, result=0, state IDLE.
  - A new start with X=(1,2,3,4) -> result=4.
  - Back-to-back run: start while in DONE -> done drops, new result computed correctly.
